// File: rtl/spd_ramp_pkg.sv
// Shared types and constants for the forward-speed ramp generator.
package spd_ramp_pkg;

  localparam int unsigned SPD_W   = 12;
  localparam int unsigned FRWRD_W = 11;

  localparam logic signed [SPD_W-1:0] SPD_MAX = 12'sh7FF;
  localparam logic signed [SPD_W-1:0] SPD_MIN = 12'sh800;

  typedef enum logic [1:0] {
    StIdle,
    StRampUp,
    StCruise,
    StRampDown
  } state_e;

endpackage

// File: rtl/spd_ramp_if.sv
// Command/status bundle between the motion controller and the speed ramp.
interface spd_ramp_if;
  import spd_ramp_pkg::*;

  logic                      strt_mv;
  logic                      stp_mv;
  logic [FRWRD_W-1:0]        max_spd;
  logic signed [SPD_W-1:0]   pid_err;
  logic signed [SPD_W-1:0]   lft_spd;
  logic signed [SPD_W-1:0]   rght_spd;
  logic                      moving;
  logic                      mv_done;

  modport master (
    output strt_mv, stp_mv, max_spd, pid_err,
    input  lft_spd, rght_spd, moving, mv_done
  );

  modport slave (
    input  strt_mv, stp_mv, max_spd, pid_err,
    output lft_spd, rght_spd, moving, mv_done
  );

endinterface

// File: rtl/spd_sat.sv
// Saturates a 13-bit signed sum into the 12-bit signed motor-command range.
module spd_sat
  import spd_ramp_pkg::*;
(
  input  logic signed [SPD_W:0]   din,
  output logic signed [SPD_W-1:0] dout
);

  always_comb begin
    dout = din[SPD_W-1:0];
    // Top two bits disagree only when the value is outside the 12-bit range.
    if (din[SPD_W] != din[SPD_W-1]) begin
      dout = din[SPD_W] ? SPD_MIN : SPD_MAX;
    end
  end

endmodule

// File: rtl/spd_ramp.sv
// Forward-speed ramp with heading correction and saturated, registered outputs.
// Optional macro SPD_RAMP_FAST_STOP_EN: decelerate at 4x the ramp step.
module spd_ramp
  import spd_ramp_pkg::*;
#(
  parameter int unsigned RAMP_DIV  = 1024,
  parameter int unsigned RAMP_STEP = 4
) (
  input  logic       clk,
  input  logic       rst,
  spd_ramp_if.slave  bus
);

  localparam int unsigned CNT_W = $clog2(RAMP_DIV);
  localparam int unsigned EXT_W = FRWRD_W + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RAMP_DIV - 1);
  localparam logic [EXT_W-1:0] UP_STEP  = EXT_W'(RAMP_STEP);
`ifdef SPD_RAMP_FAST_STOP_EN
  localparam logic [EXT_W-1:0] DN_STEP  = EXT_W'(4 * RAMP_STEP);
`else
  localparam logic [EXT_W-1:0] DN_STEP  = EXT_W'(RAMP_STEP);
`endif

  state_e                  state_q, state_d;
  logic [FRWRD_W-1:0]      frwrd_q, frwrd_d;
  logic [CNT_W-1:0]        cnt_q;
  logic                    moving_q, mv_done_q;
  logic signed [SPD_W-1:0] lft_q, rght_q;

  logic                    tick;
  logic [EXT_W-1:0]        up_sum, dn_diff;
  logic [FRWRD_W-1:0]      up_val, dn_val;
  logic signed [SPD_W:0]   sum_l, sum_r;
  logic signed [SPD_W-1:0] sat_l, sat_r;

  assign tick = (cnt_q == CNT_LAST);

  assign up_sum  = {1'b0, frwrd_q} + UP_STEP;
  assign up_val  = (up_sum > {1'b0, bus.max_spd}) ? bus.max_spd : up_sum[FRWRD_W-1:0];
  assign dn_diff = {1'b0, frwrd_q} - DN_STEP;
  assign dn_val  = ({1'b0, frwrd_q} > DN_STEP) ? dn_diff[FRWRD_W-1:0] : '0;

  assign sum_l = $signed({2'b00, frwrd_q}) + $signed({bus.pid_err[SPD_W-1], bus.pid_err});
  assign sum_r = $signed({2'b00, frwrd_q}) - $signed({bus.pid_err[SPD_W-1], bus.pid_err});

  spd_sat u_sat_l (
    .din  (sum_l),
    .dout (sat_l)
  );

  spd_sat u_sat_r (
    .din  (sum_r),
    .dout (sat_r)
  );

  always_comb begin
    state_d = state_q;
    frwrd_d = frwrd_q;
    unique case (state_q)
      StIdle: begin
        frwrd_d = '0;
        if (bus.strt_mv && !bus.stp_mv) state_d = StRampUp;
      end
      StRampUp: begin
        if (bus.stp_mv) begin
          state_d = StRampDown;
        end else begin
          if (tick) frwrd_d = up_val;
          // Compare the value being loaded so CRUISE lands on the same edge.
          if (frwrd_d == bus.max_spd) state_d = StCruise;
        end
      end
      StCruise: begin
        if (bus.stp_mv) begin
          state_d = StRampDown;
        end else if (bus.max_spd > frwrd_q) begin
          state_d = StRampUp;
        end else if (bus.max_spd < frwrd_q) begin
          frwrd_d = bus.max_spd;
        end
      end
      StRampDown: begin
        if (bus.strt_mv && !bus.stp_mv) begin
          state_d = StRampUp;
        end else begin
          if (tick) frwrd_d = dn_val;
          if (frwrd_d == '0) state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      frwrd_q   <= '0;
      cnt_q     <= '0;
      moving_q  <= 1'b0;
      mv_done_q <= 1'b0;
      lft_q     <= '0;
      rght_q    <= '0;
    end else begin
      state_q   <= state_d;
      frwrd_q   <= frwrd_d;
      // Zero throughout IDLE, so leaving IDLE always starts a fresh prescale period.
      cnt_q     <= (state_q == StIdle || tick) ? '0 : cnt_q + CNT_W'(1);
      moving_q  <= (state_d != StIdle);
      mv_done_q <= (state_q == StRampDown) && (state_d == StIdle);
      lft_q     <= (state_d == StIdle) ? '0 : sat_l;
      rght_q    <= (state_d == StIdle) ? '0 : sat_r;
    end
  end

  assign bus.lft_spd  = lft_q;
  assign bus.rght_spd = rght_q;
  assign bus.moving   = moving_q;
  assign bus.mv_done  = mv_done_q;

endmodule
